monopulse_integrator: RTL and testbench

- Pipelined, multi-channel successor to the monopulse relation stage.
- Per sample: rectifies the reference and error samples, multiplies them, and sums the products per channel over a fixed integration window of 2^LOG_INTEG samples.
- Supports a magnitude mode, |err|·|ref|, and a sign-preserving mode, err·ref.
- Sits between the channel sample mux and the angle-estimation logic, with valid/ready handshakes on both sides.

---
 rtl/monopulse_pkg.sv | 19 +
 rtl/monopulse_mult_stage.sv | 80 ++++++++
 rtl/monopulse_integrator.sv | 109 ++++++++++
 tb/tb_monopulse_integrator.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/monopulse_pkg.sv
// monopulse_pkg: shared constants and width helpers for the monopulse
// integrator.
//   MODE_MAGNITUDE / MODE_SIGNED : select |err|*|ref| or err*ref
//   ch_width()  : channel index width, at least 1 bit
//   acc_size()  : accumulator width, wide enough that a full window cannot overflow
package monopulse_pkg;

  localparam logic MODE_MAGNITUDE = 1'b0;
  localparam logic MODE_SIGNED    = 1'b1;

  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  function automatic int acc_size(input int data_size, input int log_integ);
    return 2 * data_size + log_integ;
  endfunction

endpackage

// File: rtl/monopulse_mult_stage.sv
// monopulse_mult_stage: pipeline stages 1-2 of the monopulse integrator.
//   Stage 1 rectifies the operands (magnitude mode) or passes them through
//   signed; stage 2 forms the full-width product. Both stages hold while
//   adv_i is low.
// Ports:
//   clk_i, rst_i          clock, async active-high reset
//   adv_i                 pipeline advance (low = stall)
//   valid_i, channel_i    accepted sample and its channel
//   mode_i                window mode governing this sample
//   last_i                sample closes its channel's window
//   ref_i, err_i          two's-complement operands
//   valid_o, channel_o, last_o, product_o   stage-2 outputs
module monopulse_mult_stage import monopulse_pkg::*; #(
  parameter int DATA_SIZE = 16,
  parameter int CH_W      = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          adv_i,
  input  logic                          valid_i,
  input  logic [CH_W-1:0]               channel_i,
  input  logic                          mode_i,
  input  logic                          last_i,
  input  logic [DATA_SIZE-1:0]          ref_i,
  input  logic [DATA_SIZE-1:0]          err_i,
  output logic                          valid_o,
  output logic [CH_W-1:0]               channel_o,
  output logic                          last_o,
  output logic signed [2*DATA_SIZE-1:0] product_o
);

  logic [DATA_SIZE-1:0]          ref_mag, err_mag;
  logic signed [DATA_SIZE:0]     a_d, b_d, a_q, b_q;
  logic                          v1_q, last1_q;
  logic [CH_W-1:0]               ch1_q;
  logic signed [2*DATA_SIZE-1:0] a_ext, b_ext, prod_d;

  // One extra operand bit lets the magnitude of -2^(DATA_SIZE-1) stay positive.
  always_comb begin
    ref_mag = ref_i[DATA_SIZE-1] ? -ref_i : ref_i;
    err_mag = err_i[DATA_SIZE-1] ? -err_i : err_i;
    if (mode_i == MODE_SIGNED) begin
      a_d = {ref_i[DATA_SIZE-1], ref_i};
      b_d = {err_i[DATA_SIZE-1], err_i};
    end else begin
      a_d = {1'b0, ref_mag};
      b_d = {1'b0, err_mag};
    end
  end

  // Product of two (DATA_SIZE+1)-bit values always fits 2*DATA_SIZE signed bits.
  assign a_ext  = {{(DATA_SIZE-1){a_q[DATA_SIZE]}}, a_q};
  assign b_ext  = {{(DATA_SIZE-1){b_q[DATA_SIZE]}}, b_q};
  assign prod_d = a_ext * b_ext;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v1_q      <= 1'b0;
      last1_q   <= 1'b0;
      ch1_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      valid_o   <= 1'b0;
      last_o    <= 1'b0;
      channel_o <= '0;
      product_o <= '0;
    end else if (adv_i) begin
      v1_q      <= valid_i;
      last1_q   <= last_i;
      ch1_q     <= channel_i;
      a_q       <= a_d;
      b_q       <= b_d;
      valid_o   <= v1_q;
      last_o    <= last1_q;
      channel_o <= ch1_q;
      product_o <= prod_d;
    end
  end

endmodule

// File: rtl/monopulse_integrator.sv
// monopulse_integrator: per-channel integration of reference*error products
// over windows of 2^LOG_INTEG samples, valid/ready on both sides.
// Ports:
//   i_clock, i_reset            clock, async active-high reset
//   i_valid, o_ready            sample handshake
//   i_channel, i_mode           sample channel, requested mode (first sample of window wins)
//   i_reference, i_error        signed samples
//   o_valid, i_ready            result handshake
//   o_channel, o_relation       result channel and integrated sum
module monopulse_integrator import monopulse_pkg::*; #(
  parameter  int DATA_SIZE = 16,
  parameter  int CHANNELS  = 4,
  parameter  int LOG_INTEG = 4,
  localparam int CH_W      = ch_width(CHANNELS),
  localparam int ACC_SIZE  = acc_size(DATA_SIZE, LOG_INTEG)
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [CH_W-1:0]      i_channel,
  input  logic                 i_mode,
  input  logic [DATA_SIZE-1:0] i_reference,
  input  logic [DATA_SIZE-1:0] i_error,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [CH_W-1:0]      o_channel,
  output logic [ACC_SIZE-1:0]  o_relation
);

  localparam logic [LOG_INTEG-1:0] LAST_CNT = '1;

  // Window counters and modes live at the input side so that the window mode
  // is known when stage 1 needs it; a count of zero is the IDLE state. The
  // end-of-window decision travels down the pipe as a flag.
  logic [LOG_INTEG-1:0] cnt_q  [CHANNELS];
  logic                 mode_q [CHANNELS];
  logic [ACC_SIZE-1:0]  acc_q  [CHANNELS];

  logic                          in_range, accept, win_mode, win_last, win_idle;
  logic [CH_W-1:0]               sel;
  logic                          v3, last3;
  logic [CH_W-1:0]               ch3;
  logic signed [2*DATA_SIZE-1:0] prod3;
  logic [ACC_SIZE-1:0]           prod_ext, sum_d;

  assign o_ready  = !(o_valid && !i_ready);
  assign in_range = {1'b0, i_channel} < (CH_W+1)'(CHANNELS);
  assign accept   = i_valid && o_ready && in_range;
  assign sel      = in_range ? i_channel : '0;
  assign win_idle = (cnt_q[sel] == '0);
  assign win_mode = win_idle ? i_mode : mode_q[sel];
  assign win_last = (cnt_q[sel] == LAST_CNT);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        cnt_q[c]  <= '0;
        mode_q[c] <= MODE_MAGNITUDE;
      end
    end else if (accept) begin
      cnt_q[sel] <= cnt_q[sel] + 1'b1;  // wraps to IDLE after the last sample
      if (win_idle) mode_q[sel] <= i_mode;
    end
  end

  monopulse_mult_stage #(
    .DATA_SIZE (DATA_SIZE),
    .CH_W      (CH_W)
  ) u_mult (
    .clk_i     (i_clock),
    .rst_i     (i_reset),
    .adv_i     (o_ready),
    .valid_i   (accept),
    .channel_i (i_channel),
    .mode_i    (win_mode),
    .last_i    (win_last),
    .ref_i     (i_reference),
    .err_i     (i_error),
    .valid_o   (v3),
    .channel_o (ch3),
    .last_o    (last3),
    .product_o (prod3)
  );

  assign prod_ext = {{LOG_INTEG{prod3[2*DATA_SIZE-1]}}, prod3};
  assign sum_d    = acc_q[ch3] + prod_ext;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned c = 0; c < CHANNELS; c++) acc_q[c] <= '0;
      o_valid    <= 1'b0;
      o_channel  <= '0;
      o_relation <= '0;
    end else if (o_ready) begin
      o_valid <= v3 && last3;
      if (v3) begin
        if (last3) begin
          acc_q[ch3] <= '0;
          o_channel  <= ch3;
          o_relation <= sum_d;
        end else begin
          acc_q[ch3] <= sum_d;
        end
      end
    end
  end

endmodule

// File: tb/tb_monopulse_integrator.sv
`timescale 1ns/1ps
module tb_monopulse_integrator;

  localparam int DS = 16;
  localparam int LI = 2;
  localparam int CW = 2;
  localparam int AW = 2*DS + LI;
  localparam longint MASK = (longint'(1) <<< AW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic a_valid, a_ordy, a_mode, a_ovalid, a_irdy;
  logic [CW-1:0] a_ch, a_och;
  logic [DS-1:0] a_ref, a_err;
  logic [AW-1:0] a_rel;
  logic b_valid, b_ordy, b_mode, b_ovalid, b_irdy;
  logic [CW-1:0] b_ch, b_och;
  logic [DS-1:0] b_ref, b_err;
  logic [AW-1:0] b_rel;

  monopulse_integrator #(.DATA_SIZE(DS), .CHANNELS(4), .LOG_INTEG(LI)) dut_a (
    .i_clock(clk), .i_reset(rst), .i_valid(a_valid), .o_ready(a_ordy),
    .i_channel(a_ch), .i_mode(a_mode), .i_reference(a_ref), .i_error(a_err),
    .o_valid(a_ovalid), .i_ready(a_irdy), .o_channel(a_och), .o_relation(a_rel));

  monopulse_integrator #(.DATA_SIZE(DS), .CHANNELS(3), .LOG_INTEG(LI)) dut_b (
    .i_clock(clk), .i_reset(rst), .i_valid(b_valid), .o_ready(b_ordy),
    .i_channel(b_ch), .i_mode(b_mode), .i_reference(b_ref), .i_error(b_err),
    .o_valid(b_ovalid), .i_ready(b_irdy), .o_channel(b_och), .o_relation(b_rel));

  typedef struct { int ch; longint rel; } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: per DUT, per channel window state
  int     m_cnt  [2][4];
  bit     m_mode [2][4];
  longint m_sum  [2][4];
  bit     prev_hold [2];
  int     prev_ch   [2];
  longint prev_rel  [2];
  bit     rnd_done;

  function automatic int nch(input int d);
    return (d == 0) ? 4 : 3;
  endfunction

  function automatic longint iabs(input longint x);
    return (x < 0) ? -x : x;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < 4; c++) begin
        m_cnt[d][c] = 0; m_mode[d][c] = 1'b0; m_sum[d][c] = 0;
      end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_accept(input int d, input int ch, input bit mode,
                              input logic [DS-1:0] r, input logic [DS-1:0] e);
    longint rv, ev;
    exp_t x;
    rv = longint'($signed(r));
    ev = longint'($signed(e));
    if (ch >= nch(d)) return;
    if (m_cnt[d][ch] == 0) m_mode[d][ch] = mode;
    m_sum[d][ch] += m_mode[d][ch] ? rv * ev : iabs(rv) * iabs(ev);
    m_cnt[d][ch]++;
    if (m_cnt[d][ch] == (1 << LI)) begin
      x.ch = ch;
      x.rel = m_sum[d][ch] & MASK;
      if (d == 0) q0.push_back(x); else q1.push_back(x);
      m_cnt[d][ch] = 0;
      m_sum[d][ch] = 0;
    end
  endtask

  task automatic drive(input int d, input bit v, input int ch, input bit mode,
                       input logic [DS-1:0] r, input logic [DS-1:0] e);
    logic [CW-1:0] c;
    c = ch[CW-1:0];
    if (d == 0) begin
      a_valid = v; a_ch = c; a_mode = mode; a_ref = r; a_err = e;
    end else begin
      b_valid = v; b_ch = c; b_mode = mode; b_ref = r; b_err = e;
    end
  endtask

  task automatic idle(input int d);
    drive(d, 1'b0, 0, 1'b0, '0, '0);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input int d, input int ch, input bit mode, input int r, input int e);
    bit ok;
    int tries;
    logic [DS-1:0] rr, ee;
    rr = r[DS-1:0];
    ee = e[DS-1:0];
    tries = 0;
    drive(d, 1'b1, ch, mode, rr, ee);
    do begin
      @(negedge clk);
      ok = (d == 0) ? a_ordy : b_ordy;
      @(posedge clk);
      #1;
      tries++;
    end while (!ok && tries < 500);
    if (ok) model_accept(d, ch, mode, rr, ee);
    else check("accept_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (q0.size() != 0 || q1.size() != 0) check("drain_timeout", q0.size() + q1.size(), 0);
  endtask

  task automatic mon(input int d, input logic v, input logic ir, input logic ordy,
                     input logic [CW-1:0] ch, input logic [AW-1:0] rel);
    exp_t x;
    bit have;
    string s;
    s = (d == 0) ? "a" : "b";
    check({s, "_ready"}, ordy, !(v && !ir));
    if (prev_hold[d]) begin
      check({s, "_hold_valid"}, v, 1);
      check({s, "_hold_channel"}, ch, prev_ch[d]);
      check({s, "_hold_relation"}, longint'(rel), prev_rel[d]);
    end
    if (v && ir) begin
      have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
      if (!have) begin
        check({s, "_unexpected_result"}, 1, 0);
      end else begin
        x = (d == 0) ? q0.pop_front() : q1.pop_front();
        check({s, "_channel"}, ch, x.ch);
        check({s, "_relation"}, longint'(rel), x.rel);
      end
    end
    prev_hold[d] = v && !ir;
    prev_ch[d]   = ch;
    prev_rel[d]  = longint'(rel);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_hold[0] = 1'b0;
      prev_hold[1] = 1'b0;
    end else begin
      mon(0, a_ovalid, a_irdy, a_ordy, a_och, a_rel);
      mon(1, b_ovalid, b_irdy, b_ordy, b_och, b_rel);
    end
  end

  function automatic int rnd_data();
    return ($urandom_range(0, 7) == 0) ? 32'h8000 : int'($urandom_range(0, 65535));
  endfunction

  initial begin
    rst = 1'b1;
    a_irdy = 1'b1;
    b_irdy = 1'b1;
    rnd_done = 1'b0;
    idle(0);
    idle(1);
    model_clear();
    #1;
    check("reset_o_valid", a_ovalid, 0);
    check("reset_o_channel", a_och, 0);
    check("reset_o_relation", longint'(a_rel), 0);
    check("reset_o_ready", a_ordy, 1);
    #20;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Magnitude window incl. most-negative operands, then latency
    send(0, 0, 1'b0, -3, 5);
    send(0, 0, 1'b0, 4, -2);
    send(0, 0, 1'b0, 1, 1);
    send(0, 0, 1'b0, 32'h8000, 32'h8000);
    idle(0);
    @(negedge clk); check("latency_edge1", a_ovalid, 0);
    @(negedge clk); check("latency_edge2", a_ovalid, 0);
    @(negedge clk); check("latency_edge3", a_ovalid, 1);
    @(posedge clk); #1;

    // Signed window
    send(0, 1, 1'b1, -3, 5);
    send(0, 1, 1'b1, 4, -2);
    send(0, 1, 1'b1, 2, 3);
    send(0, 1, 1'b1, 1, 1);

    // Interleaved channels
    for (int i = 0; i < 4; i++) begin
      send(0, 0, 1'b0, 1, 1);
      send(0, 2, 1'b0, 2, 2);
    end
    idle(0);
    drain();

    // Back-pressure: hold i_ready low while results pend
    a_irdy = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) send(0, 0, 1'($urandom_range(0, 1)), rnd_data(), rnd_data());
        idle(0);
      end
      begin
        repeat (14) @(posedge clk);
        #1;
        a_irdy = 1'b1;
      end
    join
    drain();

    // Async reset in the middle of a window
    send(0, 3, 1'b0, 7, 9);
    send(0, 3, 1'b0, 5, 5);
    idle(0);
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    check("midreset_o_valid", a_ovalid, 0);
    check("midreset_o_channel", a_och, 0);
    check("midreset_o_relation", longint'(a_rel), 0);
    check("midreset_o_ready", a_ordy, 1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send(0, 3, 1'b0, 1, 1);
    idle(0);
    drain();

    // Window mode retention and out-of-range discard on the 3-channel instance
    send(1, 0, 1'b0, -2, 3);
    send(1, 0, 1'b1, -1, 1);
    send(1, 0, 1'b1, -1, 1);
    send(1, 0, 1'b1, -1, 1);
    send(1, 3, 1'b1, 100, 100);
    for (int i = 0; i < 4; i++) send(1, 0, 1'b1, 1, 1);
    idle(1);
    drain();

    // Randomized traffic with random downstream back-pressure
    fork
      begin
        for (int i = 0; i < 400; i++)
          send(0, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), rnd_data(), rnd_data());
        idle(0);
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          a_irdy = ($urandom_range(0, 3) != 0);
        end
      end
    join
    a_irdy = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
